// File: rtl/fifo_wr_packer_if.sv
// Byte stream in, packed FIFO write word out, for the async_fifo write-side packer.
interface fifo_wr_packer_if #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned WR_DATA_WIDTH_MUL = 4
);
  localparam int unsigned WORD_WIDTH = DATA_WIDTH * WR_DATA_WIDTH_MUL;

  logic                  sValid;
  logic                  sReady;
  logic [DATA_WIDTH-1:0] sData;
  logic                  sLast;
  logic                  wrEn;
  logic [WORD_WIDTH-1:0] din;
  logic                  fifoFull;

  // Packer side: consumes the stream, produces the FIFO write.
  modport slave (
    input  sValid, sData, sLast, fifoFull,
    output sReady, wrEn, din
  );

  // Producer/FIFO side.
  modport master (
    output sValid, sData, sLast, fifoFull,
    input  sReady, wrEn, din
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs WR_DATA_WIDTH_MUL byte beats into one async_fifo write word; pads on sLast,
// holds the word while the FIFO is full and reloads back-to-back on the draining edge.
module fifo_wr_packer #(
  parameter int unsigned           DATA_WIDTH        = 8,
  parameter int unsigned           WR_DATA_WIDTH_MUL = 4,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE         = '0,
  parameter int unsigned           COUNT_WIDTH       = 16
) (
  input  logic                   wrClk,
  input  logic                   rst,
  fifo_wr_packer_if.slave        bus,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] wordCount,
  output logic [COUNT_WIDTH-1:0] padCount
);
  localparam int unsigned MUL        = WR_DATA_WIDTH_MUL;
  localparam int unsigned WORD_WIDTH = DATA_WIDTH * MUL;
  localparam int unsigned LANE_WIDTH = (MUL > 1) ? $clog2(MUL) : 1;
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(MUL - 1);

  logic [LANE_WIDTH-1:0]  lane_cnt;
  logic [WORD_WIDTH-1:0]  acc;
  logic                   wr_en_q;
  logic [WORD_WIDTH-1:0]  din_q;

  logic                   last_lane_c;
  logic                   out_free_c;
  logic                   ready_c;
  logic                   accept_c;
  logic                   complete_c;
  logic [WORD_WIDTH-1:0]  word_c;

  logic [LANE_WIDTH-1:0]  lane_nxt;
  logic                   wr_en_nxt;
  logic [WORD_WIDTH-1:0]  din_nxt;
  logic [COUNT_WIDTH-1:0] word_cnt_nxt;
  logic [COUNT_WIDTH-1:0] pad_cnt_nxt;
  logic                   busy_nxt;

  // Only a completing beat needs the output register; others are never stalled.
  assign last_lane_c = (lane_cnt == LAST_LANE);
  assign out_free_c  = !wr_en_q || !bus.fifoFull;
  assign ready_c     = out_free_c || (!last_lane_c && !bus.sLast);
  assign accept_c    = bus.sValid && ready_c;
  assign complete_c  = accept_c && (last_lane_c || bus.sLast);

  assign bus.sReady  = ready_c;
  assign bus.wrEn    = wr_en_q;
  assign bus.din     = din_q;

  // Word as it would leave on a completing beat: filled lanes, this beat, then pad.
  always_comb begin
    word_c = acc;
    for (int k = 0; k < int'(MUL); k++) begin
      if (LANE_WIDTH'(k) == lane_cnt) begin
        word_c[k*DATA_WIDTH +: DATA_WIDTH] = bus.sData;
      end else if (LANE_WIDTH'(k) > lane_cnt) begin
        word_c[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

  // Next-state: drain first, then a completing beat may reload on the same edge.
  always_comb begin
    lane_nxt     = lane_cnt;
    wr_en_nxt    = wr_en_q;
    din_nxt      = din_q;
    word_cnt_nxt = wordCount;
    pad_cnt_nxt  = padCount;

    if (wr_en_q && !bus.fifoFull) begin
      wr_en_nxt    = 1'b0;
      word_cnt_nxt = wordCount + COUNT_WIDTH'(1);
    end

    if (complete_c) begin
      din_nxt   = word_c;
      wr_en_nxt = 1'b1;
      lane_nxt  = '0;
      if (!last_lane_c) begin
        pad_cnt_nxt = padCount + COUNT_WIDTH'(1);
      end
    end else if (accept_c) begin
      lane_nxt = lane_cnt + LANE_WIDTH'(1);
    end

    busy_nxt = (lane_nxt != '0) || wr_en_nxt;
  end

  always_ff @(posedge wrClk or posedge rst) begin
    if (rst) begin
      lane_cnt  <= '0;
      acc       <= '0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
      wordCount <= '0;
      padCount  <= '0;
      busy      <= 1'b0;
    end else begin
      lane_cnt  <= lane_nxt;
      wr_en_q   <= wr_en_nxt;
      din_q     <= din_nxt;
      wordCount <= word_cnt_nxt;
      padCount  <= pad_cnt_nxt;
      busy      <= busy_nxt;
      if (accept_c && !complete_c) begin
        for (int k = 0; k < int'(MUL); k++) begin
          if (LANE_WIDTH'(k) == lane_cnt) begin
            acc[k*DATA_WIDTH +: DATA_WIDTH] <= bus.sData;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: a MUL=4 instance and a MUL=1 instance.
module tb_fifo_wr_packer;
  logic wrClk;
  logic rst;

  logic        busy4, busy1;
  logic [15:0] word_count4, pad_count4;
  logic [15:0] word_count1, pad_count1;

  int checks;
  int errors;

  fifo_wr_packer_if #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(4)) bus4 ();
  fifo_wr_packer_if #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1)) bus1 ();

  fifo_wr_packer #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(4), .PAD_VALUE(8'h00), .COUNT_WIDTH(16)) u_dut4 (
    .wrClk(wrClk), .rst(rst), .bus(bus4),
    .busy(busy4), .wordCount(word_count4), .padCount(pad_count4)
  );

  fifo_wr_packer #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .PAD_VALUE(8'h00), .COUNT_WIDTH(16)) u_dut1 (
    .wrClk(wrClk), .rst(rst), .bus(bus1),
    .busy(busy1), .wordCount(word_count1), .padCount(pad_count1)
  );

  initial begin
    wrClk = 1'b0;
    forever #5 wrClk = ~wrClk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wrClk);
    #1;
  endtask

  task automatic beat4(input logic [7:0] data, input logic last);
    bus4.sValid = 1'b1;
    bus4.sData  = data;
    bus4.sLast  = last;
    tick();
  endtask

  logic [7:0]  beats [64];
  logic [31:0] exp_word;
  int          words_seen;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus4.sValid = 1'b0; bus4.sData = '0; bus4.sLast = 1'b0; bus4.fifoFull = 1'b0;
    bus1.sValid = 1'b0; bus1.sData = '0; bus1.sLast = 1'b0; bus1.fifoFull = 1'b0;
    #1 rst = 1'b1;
    #2;
    // Reset state
    chk("rst_wren", 64'(bus4.wrEn), 64'd0);
    chk("rst_din", 64'(bus4.din), 64'd0);
    chk("rst_wc", 64'(word_count4), 64'd0);
    chk("rst_pc", 64'(pad_count4), 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_sready", 64'(bus4.sReady), 64'd1);
    tick();
    tick();
    rst = 1'b0;

    // Four full beats -> one word for exactly one cycle
    beat4(8'h11, 1'b0);
    beat4(8'h22, 1'b0);
    beat4(8'h33, 1'b0);
    beat4(8'h44, 1'b0);
    bus4.sValid = 1'b0;
    chk("t1_wren", 64'(bus4.wrEn), 64'd1);
    chk("t1_din", 64'(bus4.din), 64'h44332211);
    chk("t1_wc_before", 64'(word_count4), 64'd0);
    tick();
    chk("t1_wren_drop", 64'(bus4.wrEn), 64'd0);
    chk("t1_wc", 64'(word_count4), 64'd1);
    chk("t1_pc", 64'(pad_count4), 64'd0);
    chk("t1_busy", 64'(busy4), 64'd0);

    // Early sLast pads the word; next beat starts at lane 0
    beat4(8'hAA, 1'b0);
    beat4(8'hBB, 1'b1);
    bus4.sValid = 1'b0; bus4.sLast = 1'b0;
    chk("t2_wren", 64'(bus4.wrEn), 64'd1);
    chk("t2_din", 64'(bus4.din), 64'h0000BBAA);
    chk("t2_pc", 64'(pad_count4), 64'd1);
    beat4(8'hCC, 1'b1);
    bus4.sValid = 1'b0; bus4.sLast = 1'b0;
    chk("t2_lane0_din", 64'(bus4.din), 64'h000000CC);
    chk("t2_lane0_pc", 64'(pad_count4), 64'd2);
    chk("t2_wc", 64'(word_count4), 64'd2);
    tick();
    chk("t2_wc_after", 64'(word_count4), 64'd3);

    // Backpressure: word held, three beats absorbed, fourth stalls, then no-bubble reload
    bus4.fifoFull = 1'b1;
    beat4(8'h11, 1'b0);
    beat4(8'h22, 1'b0);
    beat4(8'h33, 1'b0);
    beat4(8'h44, 1'b0);
    chk("t3_pending", 64'(bus4.din), 64'h44332211);
    beat4(8'h55, 1'b0);
    beat4(8'h66, 1'b0);
    beat4(8'h77, 1'b0);
    bus4.sData = 8'h88;
    #1;
    chk("t3_stall", 64'(bus4.sReady), 64'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_hold_wren", 64'(bus4.wrEn), 64'd1);
      chk("t3_hold_din", 64'(bus4.din), 64'h44332211);
      chk("t3_hold_sready", 64'(bus4.sReady), 64'd0);
    end
    chk("t3_hold_wc", 64'(word_count4), 64'd3);
    bus4.fifoFull = 1'b0;
    #1;
    chk("t3_release_sready", 64'(bus4.sReady), 64'd1);
    tick();
    bus4.sValid = 1'b0;
    chk("t3_reload_wren", 64'(bus4.wrEn), 64'd1);
    chk("t3_reload_din", 64'(bus4.din), 64'h88776655);
    chk("t3_reload_wc", 64'(word_count4), 64'd4);
    tick();
    chk("t3_drain_wren", 64'(bus4.wrEn), 64'd0);
    chk("t3_drain_wc", 64'(word_count4), 64'd5);
    chk("t3_pc", 64'(pad_count4), 64'd2);

    // Continuous random stream against a scoreboard
    for (int i = 0; i < 64; i++) beats[i] = 8'($urandom);
    words_seen = 0;
    for (int i = 0; i < 64; i++) begin
      bus4.sValid = 1'b1;
      bus4.sData  = beats[i];
      bus4.sLast  = 1'b0;
      #1;
      chk("t4_sready", 64'(bus4.sReady), 64'd1);
      tick();
      if (bus4.wrEn === 1'b1) begin
        exp_word = {beats[4*words_seen+3], beats[4*words_seen+2],
                    beats[4*words_seen+1], beats[4*words_seen]};
        chk("t4_word", 64'(bus4.din), 64'(exp_word));
        words_seen++;
      end
    end
    bus4.sValid = 1'b0;
    tick();
    chk("t4_words_seen", 64'(words_seen), 64'd16);
    chk("t4_wc", 64'(word_count4), 64'd21);
    chk("t4_pc", 64'(pad_count4), 64'd2);

    // Async reset with a pending word and two lanes accumulated
    bus4.fifoFull = 1'b1;
    beat4(8'hA1, 1'b0);
    beat4(8'hA2, 1'b0);
    beat4(8'hA3, 1'b0);
    beat4(8'hA4, 1'b0);
    beat4(8'hB1, 1'b0);
    beat4(8'hB2, 1'b0);
    bus4.sValid = 1'b0;
    chk("t5_pre_wren", 64'(bus4.wrEn), 64'd1);
    chk("t5_pre_busy", 64'(busy4), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_wren", 64'(bus4.wrEn), 64'd0);
    chk("t5_rst_din", 64'(bus4.din), 64'd0);
    chk("t5_rst_wc", 64'(word_count4), 64'd0);
    chk("t5_rst_pc", 64'(pad_count4), 64'd0);
    chk("t5_rst_busy", 64'(busy4), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    bus4.fifoFull = 1'b0;
    beat4(8'h01, 1'b0);
    beat4(8'h02, 1'b0);
    beat4(8'h03, 1'b0);
    beat4(8'h04, 1'b0);
    bus4.sValid = 1'b0;
    chk("t5_din", 64'(bus4.din), 64'h04030201);
    chk("t5_wren", 64'(bus4.wrEn), 64'd1);
    tick();
    chk("t5_wc", 64'(word_count4), 64'd1);
    chk("t5_pc", 64'(pad_count4), 64'd0);

    // MUL=1 registered pass-through
    bus1.sValid = 1'b1; bus1.sData = 8'h5A; bus1.sLast = 1'b1;
    tick();
    chk("t6_wren_a", 64'(bus1.wrEn), 64'd1);
    chk("t6_din_a", 64'(bus1.din), 64'h5A);
    bus1.sData = 8'hA5;
    tick();
    bus1.sValid = 1'b0; bus1.sLast = 1'b0;
    chk("t6_wren_b", 64'(bus1.wrEn), 64'd1);
    chk("t6_din_b", 64'(bus1.din), 64'hA5);
    chk("t6_wc_mid", 64'(word_count1), 64'd1);
    tick();
    chk("t6_wren_off", 64'(bus1.wrEn), 64'd0);
    chk("t6_wc", 64'(word_count1), 64'd2);
    chk("t6_pc", 64'(pad_count1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
